// File: rtl/nor_mis_stim_gen.sv
// nor_mis_stim_gen: drives the two NOR MIS inputs with pairs of same-direction edges at a signed cycle skew.
// Ports: clk, rst_n (async, active low); start/abort control; cfg_skew (signed, >0 A1 leads),
//   cfg_hold (settle cycles, 0 acts as 1), cfg_count (pairs, 0 = no-op), cfg_init (starting level);
//   out_a1/out_a2 stimulus, trig (pulse on each leading edge), busy, done (pulse), pair_idx (pairs completed).
// Optional NOR_MIS_SKEW_SWEEP_EN adds cfg_step (signed, added to the skew after each pair with saturation)
//   and cur_skew (skew used by the current pair).
module nor_mis_stim_gen #(
    parameter int SKEW_W = 8,
    parameter int HOLD_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic signed [SKEW_W-1:0] cfg_skew,
    input  logic [HOLD_W-1:0]        cfg_hold,
    input  logic [CNT_W-1:0]         cfg_count,
    input  logic                     cfg_init,
`ifdef NOR_MIS_SKEW_SWEEP_EN
    input  logic signed [SKEW_W-1:0] cfg_step,
    output logic [SKEW_W-1:0]        cur_skew,
`endif
    output logic                     out_a1,
    output logic                     out_a2,
    output logic                     trig,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         pair_idx
);
    localparam logic [2:0] IDLE = 3'd0, PRE = 3'd1, LEAD = 3'd2, LAG = 3'd3, HOLD = 3'd4, DONE = 3'd5;
    localparam int CW = (HOLD_W > SKEW_W + 1) ? HOLD_W : SKEW_W + 1;
    logic [2:0]        state;
    logic [SKEW_W-1:0] skew, next_skew;
    logic [HOLD_W-1:0] hold, hold_in;
    logic [CNT_W-1:0]  count;
    logic [CW-1:0]     cnt;
    logic [SKEW_W:0]   skew_x, mag;
    logic              neg, pos, zero, cnt_end;
    // |skew| is formed one bit wider so the most negative skew keeps its full magnitude
    always_comb begin
        skew_x  = {skew[SKEW_W-1], skew};
        neg     = skew[SKEW_W-1];
        zero    = skew == '0;
        pos     = !neg && !zero;
        mag     = neg ? ~skew_x + (SKEW_W+1)'(1) : skew_x;
        hold_in = (cfg_hold == '0) ? HOLD_W'(1) : cfg_hold;
        cnt_end = cnt == CW'(1);
    end
`ifdef NOR_MIS_SKEW_SWEEP_EN
    logic [SKEW_W-1:0] step;
    logic [SKEW_W:0]   sum;
    always_comb begin
        sum       = skew_x + {step[SKEW_W-1], step};
        next_skew = (sum[SKEW_W] == sum[SKEW_W-1]) ? sum[SKEW_W-1:0] : {sum[SKEW_W], {(SKEW_W-1){~sum[SKEW_W]}}};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) step <= '0;
        else if (state == IDLE && start) step <= cfg_step;
    end
    assign cur_skew = skew;
`else
    assign next_skew = skew;
`endif
    // Edges are applied on entry to a state: LEAD entry carries the leading edge, HOLD entry the lagging one.
    // With zero skew both edges land together and the pair goes straight to HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            skew     <= '0;
            hold     <= '0;
            count    <= '0;
            out_a1   <= 1'b0;
            out_a2   <= 1'b0;
            trig     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pair_idx <= '0;
        end else begin
            trig <= 1'b0;
            done <= 1'b0;
            if (busy && abort) begin
                state <= IDLE;
                busy  <= 1'b0;
                // a pending lagging edge still lands so both outputs are left equal
                if (state == LEAD || state == LAG) begin
                    out_a1 <= out_a1 ^ neg;
                    out_a2 <= out_a2 ^ pos;
                end
            end else begin
                case (state)
                    IDLE: if (start) begin
                        out_a1   <= cfg_init;
                        out_a2   <= cfg_init;
                        busy     <= 1'b1;
                        pair_idx <= '0;
                        skew     <= cfg_skew;
                        hold     <= hold_in;
                        count    <= cfg_count;
                        cnt      <= CW'(hold_in);
                        state    <= (cfg_count == '0) ? DONE : PRE;
                    end
                    PRE, HOLD: begin
                        if (!cnt_end) cnt <= cnt - CW'(1);
                        else if (state == HOLD && pair_idx == count) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            trig   <= 1'b1;
                            out_a1 <= out_a1 ^ ~neg;
                            out_a2 <= out_a2 ^ ~pos;
                            if (zero) begin
                                pair_idx <= pair_idx + CNT_W'(1);
                                skew     <= next_skew;
                                cnt      <= CW'(hold);
                                state    <= HOLD;
                            end else begin
                                cnt   <= CW'(mag);
                                state <= LEAD;
                            end
                        end
                    end
                    LEAD, LAG: begin
                        if (!cnt_end) begin
                            cnt   <= cnt - CW'(1);
                            state <= LAG;
                        end else begin
                            out_a1   <= out_a1 ^ neg;
                            out_a2   <= out_a2 ^ pos;
                            pair_idx <= pair_idx + CNT_W'(1);
                            skew     <= next_skew;
                            cnt      <= CW'(hold);
                            state    <= HOLD;
                        end
                    end
                    // an empty run reaches DONE still busy and spends one extra cycle to show busy then done
                    DONE: begin
                        if (busy) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_nor_mis_stim_gen.sv
// tb_nor_mis_stim_gen: scoreboard bench for nor_mis_stim_gen; expected output events are queued at
//   stimulus time and matched cycle-exactly by a monitor on every trig/done pulse or output level change.
module tb_nor_mis_stim_gen;
    logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0, cfg_init = 1'b0;
    logic [7:0]  cfg_skew = '0;
    logic [15:0] cfg_hold = '0, cfg_count = '0;
    logic        out_a1, out_a2, trig, busy, done;
    logic [15:0] pair_idx;
    int          n_tests = 0, n_fail = 0, cyc = 0, acc = 0;
    typedef struct {
        string       tag;
        int          cyc;
        logic        a1, a2, tg, dn, bs;
        logic [15:0] idx;
    } ev_t;
    ev_t q[$];

    nor_mis_stim_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_skew(cfg_skew), .cfg_hold(cfg_hold), .cfg_count(cfg_count), .cfg_init(cfg_init),
        .out_a1(out_a1), .out_a2(out_a2), .trig(trig), .busy(busy), .done(done), .pair_idx(pair_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic run(input logic [7:0] s, input logic [15:0] h, input logic [15:0] c, input logic i);
        @(negedge clk);
        cfg_skew = s; cfg_hold = h; cfg_count = c; cfg_init = i; start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        start = 1'b0;
    endtask

    task automatic exp(input string tag, input int k, input logic a1, input logic a2,
                       input logic tg, input logic dn, input logic bs, input int idx);
        ev_t e;
        e.tag = tag; e.cyc = acc + k; e.a1 = a1; e.a2 = a2; e.tg = tg; e.dn = dn; e.bs = bs;
        e.idx = 16'(idx);
        q.push_back(e);
    endtask

    task automatic drain(input string tag, input int bound);
        for (int i = 0; i < bound && q.size() != 0; i++) @(negedge clk);
        check({tag, "_drained"}, q.size(), 0);
        q.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [1:0] prev;
        ev_t e;
        prev = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) prev = {out_a1, out_a2};
            else if (trig || done || {out_a1, out_a2} != prev) begin
                prev = {out_a1, out_a2};
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got cyc=%0d a1=%b a2=%b trig=%b done=%b busy=%b idx=%0d expected none",
                             cyc, out_a1, out_a2, trig, done, busy, pair_idx);
                end else begin
                    e = q.pop_front();
                    if (cyc != e.cyc || out_a1 !== e.a1 || out_a2 !== e.a2 || trig !== e.tg ||
                        done !== e.dn || busy !== e.bs || pair_idx !== e.idx) begin
                        n_fail++;
                        $display("FAIL %s: got cyc=%0d a1=%b a2=%b trig=%b done=%b busy=%b idx=%0d expected cyc=%0d a1=%b a2=%b trig=%b done=%b busy=%b idx=%0d",
                                 e.tag, cyc, out_a1, out_a2, trig, done, busy, pair_idx,
                                 e.cyc, e.a1, e.a2, e.tg, e.dn, e.bs, e.idx);
                    end
                end
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_a1", out_a1, 0);
        check("rst_a2", out_a2, 0);
        check("rst_trig", trig, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", pair_idx, 0);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        // skew +3, hold 5, two pairs; cfg and a second start mid-run must be ignored
        run(8'd3, 16'd5, 16'd2, 1'b0);
        exp("p3_lead1", 5, 1, 0, 1, 0, 1, 0);
        exp("p3_lag1", 8, 1, 1, 0, 0, 1, 1);
        exp("p3_lead2", 13, 0, 1, 1, 0, 1, 1);
        exp("p3_lag2", 16, 0, 0, 0, 0, 1, 2);
        exp("p3_done", 21, 0, 0, 0, 1, 0, 2);
        cfg_skew = 8'hFF; cfg_hold = 16'd0; cfg_count = 16'd7; cfg_init = 1'b1;
        while (cyc < acc + 10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain("p3", 40);
        check("p3_idx_final", pair_idx, 2);
        check("p3_busy_final", busy, 0);
        // skew -128: A2 falls first, A1 exactly 128 cycles later
        run(8'h80, 16'd2, 16'd1, 1'b1);
        exp("n128_init", 0, 1, 1, 0, 0, 1, 0);
        exp("n128_lead", 2, 1, 0, 1, 0, 1, 0);
        exp("n128_lag", 130, 0, 0, 0, 0, 1, 1);
        exp("n128_done", 132, 0, 0, 0, 1, 0, 1);
        drain("n128", 200);
        // zero skew, zero hold: both toggle every cycle, three times
        run(8'd0, 16'd0, 16'd3, 1'b0);
        exp("z_pair1", 1, 1, 1, 1, 0, 1, 1);
        exp("z_pair2", 2, 0, 0, 1, 0, 1, 2);
        exp("z_pair3", 3, 1, 1, 1, 0, 1, 3);
        exp("z_done", 4, 1, 1, 0, 1, 0, 3);
        drain("z", 20);
        // empty run: outputs take cfg_init, busy one cycle, then done, no trig
        run(8'd5, 16'd7, 16'd0, 1'b0);
        exp("c0_init", 0, 0, 0, 0, 0, 1, 0);
        exp("c0_done", 1, 0, 0, 0, 1, 0, 0);
        drain("c0", 20);
        // abort between the leading and lagging edge
        run(8'd10, 16'd3, 16'd2, 1'b0);
        exp("ab_lead", 3, 1, 0, 1, 0, 1, 0);
        exp("ab_lag", 6, 1, 1, 0, 0, 0, 0);
        while (cyc < acc + 5) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        drain("ab", 20);
        check("ab_busy", busy, 0);
        // next start after abort is accepted
        run(8'd1, 16'd1, 16'd1, 1'b0);
        exp("s1_init", 0, 0, 0, 0, 0, 1, 0);
        exp("s1_lead", 1, 1, 0, 1, 0, 1, 0);
        exp("s1_lag", 2, 1, 1, 0, 0, 1, 1);
        exp("s1_done", 3, 1, 1, 0, 1, 0, 1);
        drain("s1", 20);
        // asynchronous reset in the middle of LAG
        run(8'd20, 16'd1, 16'd1, 1'b0);
        exp("rl_init", 0, 0, 0, 0, 0, 1, 0);
        exp("rl_lead", 1, 1, 0, 1, 0, 1, 0);
        while (cyc < acc + 5) @(negedge clk);
        check("rl_q_seen", q.size(), 0);
        #2 rst_n = 1'b0;
        #1;
        check("rl_a1", out_a1, 0);
        check("rl_a2", out_a2, 0);
        check("rl_busy", busy, 0);
        check("rl_trig", trig, 0);
        check("rl_idx", pair_idx, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        // back in IDLE: start together with abort is taken
        abort = 1'b1;
        run(8'd3, 16'd4, 16'd0, 1'b0);
        abort = 1'b0;
        exp("sa_done", 1, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        check("sa_busy", busy, 1);
        drain("sa", 20);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
